fir_data_ring_ctrl: RTL

// Upstream sequencer for the FIR tap and data RAMs (1-cycle read-latency, word-addressed, dual-port).

---
 rtl/fir_data_ring_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_data_ring_ctrl.sv
// Sequencer for the FIR tap/data RAMs: clears and fills a circular sample ring, then issues
// one (tap[k], x[n-k]) read pair per tap and flags each pair for the MAC one cycle later.
module fir_data_ring_ctrl #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned NUM_TAP    = 11,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst_n,
   input  logic                  ap_start,
   input  logic                  ss_tvalid,
   input  logic [DATA_WIDTH-1:0] ss_tdata,
   input  logic                  ss_tlast,
   output logic                  ss_tready,
   input  logic                  y_busy,
   output logic                  data_we,
   output logic [ADDR_WIDTH-1:0] data_waddr,
   output logic [DATA_WIDTH-1:0] data_di,
   output logic                  data_re,
   output logic [ADDR_WIDTH-1:0] data_raddr,
   output logic                  tap_re,
   output logic [ADDR_WIDTH-1:0] tap_raddr,
   output logic                  mac_valid,
   output logic                  mac_first,
   output logic                  mac_last,
   output logic                  done
);

   typedef enum logic [2:0] {
      StIdle, StClear, StWaitIn, StWrite, StRead, StDrain, StDone
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LastIdx   = ADDR_WIDTH'(NUM_TAP - 1);
   localparam logic [ADDR_WIDTH:0]   NumTapExt = (ADDR_WIDTH + 1)'(NUM_TAP);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   head_q;
   logic [DATA_WIDTH-1:0]   sample_q;
   logic                    last_q;
   logic                    mac_valid_q, mac_first_q, mac_last_q;

   logic                    reading;
   logic [ADDR_WIDTH:0]     ring_sum;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         head_q      <= '0;
         sample_q    <= '0;
         last_q      <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_first_q <= 1'b0;
         mac_last_q  <= 1'b0;
      end else begin
         // Delayed copies of the read issue line up with the RAM read-data cycle.
         mac_valid_q <= (state_q == StRead);
         mac_first_q <= (state_q == StRead) && (cnt_q == '0);
         mac_last_q  <= (state_q == StRead) && (cnt_q == LastIdx);
         unique case (state_q)
            StIdle, StDone: begin
               if (ap_start) begin
                  state_q <= StClear;
                  cnt_q   <= '0;
                  head_q  <= '0;
               end
            end
            StClear: begin
               if (cnt_q == LastIdx) begin
                  state_q <= StWaitIn;
                  cnt_q   <= '0;
                  head_q  <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWaitIn: begin
               if (ss_tvalid && !y_busy) begin
                  sample_q <= ss_tdata;
                  last_q   <= ss_tlast;
                  state_q  <= StWrite;
               end
            end
            StWrite: begin
               state_q <= StRead;
               cnt_q   <= '0;
            end
            StRead: begin
               if (cnt_q == LastIdx) begin
                  state_q <= StDrain;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDrain: begin
               head_q  <= (head_q == LastIdx) ? '0 : head_q + 1'b1;
               state_q <= last_q ? StDone : StWaitIn;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign reading = (state_q == StRead);

   // x[n-k] lives at head-k, wrapped back into the ring when k passes head.
   always_comb begin
      ring_sum = {1'b0, head_q} - {1'b0, cnt_q};
      if (head_q < cnt_q) begin
         ring_sum = {1'b0, head_q} + NumTapExt - {1'b0, cnt_q};
      end
   end

   always_comb begin
      ss_tready  = (state_q == StWaitIn) && !y_busy;
      data_we    = (state_q == StClear) || (state_q == StWrite);
      data_waddr = '0;
      if (state_q == StClear) data_waddr = cnt_q;
      if (state_q == StWrite) data_waddr = head_q;
      data_di    = (state_q == StWrite) ? sample_q : '0;
      data_re    = reading;
      tap_re     = reading;
      tap_raddr  = reading ? cnt_q : '0;
      data_raddr = reading ? ring_sum[ADDR_WIDTH-1:0] : '0;
      mac_valid  = mac_valid_q;
      mac_first  = mac_first_q;
      mac_last   = mac_last_q;
      done       = (state_q == StDone);
   end

endmodule
